// File: rtl/mio_pkg.sv
// Shared types and address map for the memory/IO bus responder.
package mio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_RESP
  } mio_state_e;

  typedef enum logic [2:0] {
    RGN_RAM,
    RGN_GPIO,
    RGN_SW,
    RGN_CNT,
    RGN_NONE
  } mio_region_e;

  localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] RAM_MASK  = 32'hFFFF_F000;
  localparam logic [31:0] GPIO_ADDR = 32'hE000_0000;
  localparam logic [31:0] SW_ADDR   = 32'hF000_0000;
  localparam logic [31:0] CNT_ADDR  = 32'hF000_0004;

endpackage

// File: rtl/mio_addr_decode.sv
// Combinational word-address decode into a bus region; byte offset is not an input.
module mio_addr_decode
  import mio_pkg::*;
(
  input  logic [31:2]  word_addr,
  output mio_region_e  region,
  output logic         unmapped
);

  always_comb begin
    region = RGN_NONE;
    if ((word_addr & RAM_MASK[31:2]) == RAM_BASE[31:2]) begin
      region = RGN_RAM;
    end else if (word_addr == GPIO_ADDR[31:2]) begin
      region = RGN_GPIO;
    end else if (word_addr == SW_ADDR[31:2]) begin
      region = RGN_SW;
    end else if (word_addr == CNT_ADDR[31:2]) begin
      region = RGN_CNT;
    end
    unmapped = (region == RGN_NONE);
  end

endmodule

// File: rtl/mio_bus_responder.sv
// CPU memory/IO responder: one access at a time, RAM wait states, one-cycle mio_ready.
// Optional bus_err output when MIO_BUSERR_EN is defined.
module mio_bus_responder
  import mio_pkg::*;
#(
  parameter int unsigned RAM_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mio,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [31:0] addr_bus,
  input  logic [31:0] cpu_data_out,
  output logic [31:0] cpu_data_in,
  output logic        mio_ready,
  output logic [9:0]  ram_addr,
  output logic        ram_we,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  output logic [31:0] gpio_out,
  input  logic [15:0] sw,
  input  logic [31:0] counter_val,
  output logic        counter_we,
  output logic [31:0] counter_din
`ifdef MIO_BUSERR_EN
  ,
  output logic        bus_err
`endif
);

  localparam logic [2:0] WAIT_LAST = 3'(RAM_WAIT - 1);

  mio_state_e  state_q, state_d;
  logic [31:2] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        is_wr_q, is_wr_d;
  logic [2:0]  wait_q, wait_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] gpio_q, gpio_d;

  mio_region_e region;
  logic        unmapped;
  logic        unused_byte_offset;

  assign unused_byte_offset = ^addr_bus[1:0];

  mio_addr_decode u_decode (
    .word_addr (addr_q),
    .region    (region),
    .unmapped  (unmapped)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      wait_q  <= '0;
      rdata_q <= '0;
      gpio_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
      gpio_q  <= gpio_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_wr_d    = is_wr_q;
    wait_d     = wait_q;
    rdata_d    = rdata_q;
    gpio_d     = gpio_q;
    ram_we     = 1'b0;
    counter_we = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_mio && (mem_r || mem_w)) begin
          addr_d  = addr_bus[31:2];
          wdata_d = cpu_data_out;
          is_wr_d = mem_w;  // write wins when both kinds are requested
          wait_d  = '0;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        ram_we     = is_wr_q && (region == RGN_RAM) && (wait_q == '0);
        counter_we = is_wr_q && (region == RGN_CNT) && (wait_q == '0);
        if (!is_wr_q && (region == RGN_RAM) && (wait_q != WAIT_LAST)) begin
          wait_d = wait_q + 3'd1;
        end else begin
          wait_d  = '0;
          state_d = ST_RESP;
          if (is_wr_q) begin
            rdata_d = '0;
            if (region == RGN_GPIO) gpio_d = wdata_q;
          end else begin
            case (region)
              RGN_RAM:  rdata_d = ram_dout;
              RGN_GPIO: rdata_d = gpio_q;
              RGN_SW:   rdata_d = {16'b0, sw};
              RGN_CNT:  rdata_d = counter_val;
              default:  rdata_d = '0;
            endcase
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign mio_ready   = (state_q == ST_RESP);
  assign cpu_data_in = rdata_q;
  assign gpio_out    = gpio_q;
  assign ram_addr    = addr_q[11:2];
  assign ram_din     = wdata_q;
  assign counter_din = wdata_q;

`ifdef MIO_BUSERR_EN
  assign bus_err = mio_ready && (unmapped || (is_wr_q && (region == RGN_SW)));
`else
  logic unused_unmapped;
  assign unused_unmapped = unmapped;
`endif

endmodule

// File: tb/tb_mio_bus_responder.sv
// Scoreboard bench for mio_bus_responder; bus_err is checked when MIO_BUSERR_EN is defined.
module tb_mio_bus_responder;

  localparam int RAM_WAIT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_mio = 1'b0, mem_r = 1'b0, mem_w = 1'b0;
  logic [31:0] addr_bus = '0, cpu_data_out = '0;
  logic [31:0] cpu_data_in;
  logic        mio_ready;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_din, ram_dout;
  logic [31:0] gpio_out;
  logic [15:0] sw = '0;
  logic [31:0] counter_val = '0;
  logic        counter_we;
  logic [31:0] counter_din;
`ifdef MIO_BUSERR_EN
  logic        bus_err;
`endif

  always #5 clk = ~clk;

  mio_bus_responder #(.RAM_WAIT(RAM_WAIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_mio      (cpu_mio),
    .mem_r        (mem_r),
    .mem_w        (mem_w),
    .addr_bus     (addr_bus),
    .cpu_data_out (cpu_data_out),
    .cpu_data_in  (cpu_data_in),
    .mio_ready    (mio_ready),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout),
    .gpio_out     (gpio_out),
    .sw           (sw),
    .counter_val  (counter_val),
    .counter_we   (counter_we),
    .counter_din  (counter_din)
`ifdef MIO_BUSERR_EN
    ,
    .bus_err      (bus_err)
`endif
  );

  // Simple RAM: combinational read, write on the rising edge.
  logic [31:0] mem [0:1023];
  assign ram_dout = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int ready_cnt = 0;
  int ram_we_cnt = 0, cnt_we_cnt = 0;
  logic [9:0]  last_ram_addr = '0;
  logic [31:0] last_ram_din = '0, last_cnt_din = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (ram_we) begin
      ram_we_cnt++;
      last_ram_addr = ram_addr;
      last_ram_din  = ram_din;
    end
    if (counter_we) begin
      cnt_we_cnt++;
      last_cnt_din = counter_din;
    end
    if (mio_ready) begin
      exp_t e;
      ready_cnt++;
      if (sb_q.size() == 0) begin
        check("spurious_ready", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("rdata", cpu_data_in, e.data);
`ifdef MIO_BUSERR_EN
        check("bus_err", {31'b0, bus_err}, {31'b0, e.err});
`endif
      end
    end
  end

  // Drive one request for a single edge, then count edges until mio_ready.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_data,
                        input logic exp_err, input int exp_lat, input string tag);
    exp_t e;
    int lat;
    @(negedge clk);
    cpu_mio = 1'b1; mem_r = r; mem_w = w; addr_bus = a; cpu_data_out = d;
    e.data = exp_data;
    e.err  = exp_err;
    sb_q.push_back(e);
    @(negedge clk);
    cpu_mio = 1'b0; mem_r = 1'b0; mem_w = 1'b0;
    lat = 0;
    while (!mio_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int we0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, mio_ready}, 32'd0);
    check("rst_rdata", cpu_data_in, 32'd0);
    check("rst_gpio", gpio_out, 32'd0);
    check("rst_ram_we", {31'b0, ram_we}, 32'd0);
    check("rst_cnt_we", {31'b0, counter_we}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // RAM write then read back through the wait states.
    we0 = ram_we_cnt;
    access(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 1, "ram_wr");
    check("ram_we_cycles", ram_we_cnt - we0, 1);
    check("ram_addr", {22'b0, last_ram_addr}, 32'd4);
    check("ram_din", last_ram_din, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 32'h0000_0013, 32'h0, 32'hDEAD_BEEF, 1'b0, RAM_WAIT, "ram_rd");

    // GPIO write is visible from the edge leaving ACC; read returns it.
    access(1'b0, 1'b1, 32'hE000_0000, 32'h0000_00A5, 32'h0, 1'b0, 1, "gpio_wr");
    check("gpio_out", gpio_out, 32'h0000_00A5);
    access(1'b1, 1'b0, 32'hE000_0002, 32'h0, 32'h0000_00A5, 1'b0, 1, "gpio_rd");

    sw = 16'h8001;
    access(1'b1, 1'b0, 32'hF000_0000, 32'h0, 32'h0000_8001, 1'b0, 1, "sw_rd");
    access(1'b0, 1'b1, 32'hF000_0000, 32'h1234, 32'h0, 1'b1, 1, "sw_wr");

    counter_val = 32'h0BAD_F00D;
    access(1'b1, 1'b0, 32'hF000_0004, 32'h0, 32'h0BAD_F00D, 1'b0, 1, "cnt_rd");
    we0 = cnt_we_cnt;
    access(1'b0, 1'b1, 32'hF000_0004, 32'd7, 32'h0, 1'b0, 1, "cnt_wr");
    check("cnt_we_cycles", cnt_we_cnt - we0, 1);
    check("cnt_din", last_cnt_din, 32'd7);
    // Read and write together is treated as a write.
    we0 = cnt_we_cnt;
    access(1'b1, 1'b1, 32'hF000_0004, 32'd9, 32'h0, 1'b0, 1, "cnt_rw");
    check("rw_is_write", cnt_we_cnt - we0, 1);
    check("rw_cnt_din", last_cnt_din, 32'd9);

    access(1'b1, 1'b0, 32'h1234_0000, 32'h0, 32'h0, 1'b1, 1, "unmapped_rd");
    access(1'b1, 1'b0, 32'h0000_1000, 32'h0, 32'h0, 1'b1, 1, "ram_edge_rd");
    access(1'b1, 1'b0, 32'h0000_0FFC, 32'h0, 32'h0000_0FFC, 1'b0, RAM_WAIT, "ram_top_rd");

    // Reset during ACC of a GPIO write: committed value is lost, no ready.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("gpio_after_reset", gpio_out, 32'd0);
    we0 = ready_cnt;
    cpu_mio = 1'b1; mem_w = 1'b1; addr_bus = 32'hE000_0000; cpu_data_out = 32'h55;
    @(negedge clk);
    cpu_mio = 1'b0; mem_w = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("abort_gpio", gpio_out, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_ready", ready_cnt - we0, 0);
    check("abort_gpio_late", gpio_out, 32'd0);
    access(1'b1, 1'b0, 32'hE000_0000, 32'h0, 32'h0, 1'b0, 1, "post_abort_rd");

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Preload the top RAM word used by the boundary read.
  initial mem[1023] = 32'h0000_0FFC;

endmodule
